// File: rtl/steering_feedback_rx.sv
// steering_feedback_rx
//   Return path of the steering link. Receives 4-byte position/status frames
//   (0xA5, HI, LO, CHK) from the steering Arduino over an 8N1 UART line, validates
//   them and presents the steering angle and status flags. Also runs a link-stale
//   watchdog and a saturating rejected-frame counter for debug.
//
//   HI[0] = position[8], HI[1] = home, HI[2] = fault, HI[7:3] must be zero.
//   LO    = position[7:0].  CHK = 0xA5 ^ HI ^ LO.
//
// Ports
//   CLOCK_50          in   system clock
//   reset_n           in   asynchronous active-low reset
//   rx_Ard            in   serial line from the Arduino, idle high, LSB first
//   currentDirection  out  last valid steering position (9 bits)
//   home_Ack          out  Arduino reports home/position reset complete
//   motor_Fault       out  Arduino reports steering motor fault
//   update_Valid      out  one-cycle pulse when the three outputs above load
//   link_Stale        out  no valid frame for TIMEOUT_CYCLES cycles
//   frame_Errors      out  rejected-frame count, saturating at 255
module steering_feedback_rx #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int GAP_CYCLES     = 17_360
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       rx_Ard,
  output logic [8:0] currentDirection,
  output logic       home_Ack,
  output logic       motor_Fault,
  output logic       update_Valid,
  output logic       link_Stale,
  output logic [7:0] frame_Errors
);

  localparam int BCW = $clog2(CLKS_PER_BIT + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_MAX   = TCW'(TIMEOUT_CYCLES);
  localparam logic [7:0]     SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    P_SYNC, P_HI, P_LO, P_CHK
  } p_state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Reset to the idle (high) level.
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;
  logic rx_s;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_Ard;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // Counts the first cycles out of reset. The synchroniser comes out of reset
  // holding 1 regardless of the real line, so WAIT_HIGH only trusts rx_s once
  // both flops have been refilled from the pin; otherwise a line held low
  // through reset would look like a fresh start bit.
  logic [1:0] boot_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)             boot_q <= 2'd0;
    else if (boot_q != 2'd3)  boot_q <= boot_q + 2'd1;
  end

  // ---------------------------------------------------------------------------
  // UART receive FSM
  // ---------------------------------------------------------------------------
  rx_state_e      rx_state_q, rx_state_d;
  logic [BCW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           byte_vld;   // stop bit sampled high: shreg_q holds a byte
  logic           frame_err;  // stop bit sampled low

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    clk_cnt_d  = clk_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    byte_vld   = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        // First cycle out of reset: never start on whatever the line shows.
        if (boot_q == 2'd0) rx_state_d = RX_WAIT_HIGH;
        else if (!rx_s)     rx_state_d = RX_START;
      end
      RX_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          // High at mid-start is a glitch; silently back to idle.
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shreg_d   = {rx_s, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            byte_vld   = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err  = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        clk_cnt_d = '0;
        if (rx_s && boot_q == 2'd3) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------
  p_state_e       p_state_q, p_state_d;
  logic [7:0]     hi_q, hi_d;
  logic [7:0]     lo_q, lo_d;
  logic [GCW-1:0] gap_q, gap_d;
  logic           rx_busy;
  logic           load;       // CHK matched: latch outputs this edge
  logic           perr;       // parser-level rejection
  logic           err_inc;

  assign rx_busy = (rx_state_q == RX_START) || (rx_state_q == RX_DATA) ||
                   (rx_state_q == RX_STOP);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      p_state_q <= P_SYNC;
      hi_q      <= '0;
      lo_q      <= '0;
      gap_q     <= '0;
    end else begin
      p_state_q <= p_state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      gap_q     <= gap_d;
    end
  end

  always_comb begin
    p_state_d = p_state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    load      = 1'b0;
    perr      = 1'b0;
    // Gap timer only runs mid-frame while the line is genuinely idle.
    if (p_state_q == P_SYNC || byte_vld || rx_busy) gap_d = '0;
    else                                             gap_d = gap_q + 1'b1;

    if (frame_err) begin
      p_state_d = P_SYNC;
    end else if (byte_vld) begin
      unique case (p_state_q)
        P_SYNC: if (shreg_q == SYNC_BYTE) p_state_d = P_HI;
        P_HI: begin
          hi_d = shreg_q;
          if (shreg_q[7:3] != 5'd0) begin
            perr      = 1'b1;
            p_state_d = P_SYNC;
          end else begin
            p_state_d = P_LO;
          end
        end
        P_LO: begin
          lo_d      = shreg_q;
          p_state_d = P_CHK;
        end
        P_CHK: begin
          p_state_d = P_SYNC;
          if (shreg_q == (SYNC_BYTE ^ hi_q ^ lo_q)) load = 1'b1;
          else                                      perr = 1'b1;
        end
        default: p_state_d = P_SYNC;
      endcase
    end else if (p_state_q != P_SYNC && gap_q == GAP_LAST) begin
      perr      = 1'b1;
      p_state_d = P_SYNC;
    end
  end

  assign err_inc = frame_err | perr;

  // ---------------------------------------------------------------------------
  // Output registers, stale watchdog, error counter
  // ---------------------------------------------------------------------------
  logic [8:0]     dir_q;
  logic           home_q, fault_q, upd_q, stale_q;
  logic [TCW-1:0] stale_cnt_q;
  logic [7:0]     err_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      dir_q       <= '0;
      home_q      <= 1'b0;
      fault_q     <= 1'b0;
      upd_q       <= 1'b0;
      stale_q     <= 1'b1;
      stale_cnt_q <= '0;
      err_q       <= '0;
    end else begin
      upd_q <= load;
      if (load) begin
        dir_q   <= {hi_q[0], lo_q};
        home_q  <= hi_q[1];
        fault_q <= hi_q[2];
      end
      // A load wins over the threshold landing in the same cycle.
      if (load) begin
        stale_cnt_q <= '0;
        stale_q     <= 1'b0;
      end else begin
        if (stale_cnt_q != TMO_MAX)  stale_cnt_q <= stale_cnt_q + 1'b1;
        if (stale_cnt_q == TMO_LAST) stale_q     <= 1'b1;
      end
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign currentDirection = dir_q;
  assign home_Ack         = home_q;
  assign motor_Fault      = fault_q;
  assign update_Valid     = upd_q;
  assign link_Stale       = stale_q;
  assign frame_Errors     = err_q;

endmodule
